bus_addr_dec: RTL and testbench
===============================

Name: bus_addr_dec

Overview:
Bus address decoder for the shared SoC bus. It maps the word address driven by the current bus owner onto one of eight active-low slave chip selects, using the top three address bits. It sits between the bus arbiter/master mux output (s_addr) and the slave mux/slaves. Chip selects are registered to ease bus timing.

Parameters:
WORD_ADDR_W, 30, width of the shared word address bus (from shared package; not overridden per instance)
SLAVE_IDX_W, 3, width of slave index field; 2**SLAVE_IDX_W = 8 slaves
SLAVE_IDX_MSB, 29, MSB of slave index field; field is s_addr[29:27]

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
s_addr  input  30  shared word address bus [29:0]
s0_cs_n  output  1  slave 0 chip select, active low
s1_cs_n  output  1  slave 1 chip select, active low
s2_cs_n  output  1  slave 2 chip select, active low
s3_cs_n  output  1  slave 3 chip select, active low
s4_cs_n  output  1  slave 4 chip select, active low
s5_cs_n  output  1  slave 5 chip select, active low
s6_cs_n  output  1  slave 6 chip select, active low
s7_cs_n  output  1  slave 7 chip select, active low

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset), sampled on clk rising edge.
- Slave index idx = s_addr[29:27]; s_addr[26:0] ignored entirely.
- Decode: cs_n[k] next = 0 when idx == k, else 1; exactly one select low.
- Word-address windows (each 0x0800_0000 words): s0 0x0000_0000-0x07FF_FFFF, s1 0x0800_0000-0x0FFF_FFFF, s2 0x1000_0000-0x17FF_FFFF, s3 0x1800_0000-0x1FFF_FFFF, s4 0x2000_0000-0x27FF_FFFF, s5 0x2800_0000-0x2FFF_FFFF, s6 0x3000_0000-0x37FF_FFFF, s7 0x3800_0000-0x3FFF_FFFF.
- Latency: one cycle. s_addr sampled at edge N appears on cs_n after edge N.
- Reset: while reset=1 at an edge, all eight cs_n register to 1 (no slave selected); reset has priority over decode.
- After reset deasserts, the first edge loads the decode of the current s_addr.
- Reset mid-operation: the next edge forces all cs_n high regardless of s_addr. No partial/held state.
- X/Z on s_addr[29:27]: undefined, not required to propagate safely.
- One-hot invariant: outside reset, exactly one cs_n is 0 every cycle; during/after reset, until the first decode, all are 1.
- No other state; no handshake; s_addr may change every cycle.

Decomposition:
- Shared package/defines: WORD_ADDR_W=30, WORD_ADDR_BUS [29:0], BUS_SLAVE_INDEX_LOC [29:27], BUS_SLAVE_INDEX_W=3, slave index constants BUS_SLAVE_0..BUS_SLAVE_7 (3'h0..3'h7), ENABLE_N=1'b0, DISABLE_N=1'b1, RESET_ENABLE=1'b1.
- Optional combinational sub-module bus_slave_idx_dec (3-bit index to 8-bit active-low one-hot). The top level keeps the registers and per-slave output fanout.

Test Plan:
- Reset: reset=1 for 2 cycles with s_addr=0x0000_0000 -> all s0..s7_cs_n = 1; the first edge after release drives s0_cs_n=0, others 1.
- Full sweep: s_addr from 0x0000_0000 to 0x3F00_0000 in steps of 0x0100_0000, one per cycle -> one cycle later, cs_n index = s_addr>>27. Examples: 0x0700_0000 gives s0; 0x0800_0000 gives s1; 0x3F00_0000 gives s7.
- Window boundaries: 0x07FF_FFFF then 0x0800_0000 on consecutive cycles -> s0 low then s1 low, exactly one low each cycle.
- Low bits ignored: s_addr=0x2000_0000 and 0x27FF_FFFF -> both give s4_cs_n=0 only.
- Latency/back-to-back: alternate 0x0000_0000 and 0x3800_0000 every cycle -> s0 and s7 alternate low, each delayed by exactly one cycle.
- Reset mid-stream: s_addr=0x1800_0000 (s3 low), then assert reset for 1 cycle -> all cs_n=1 next edge; deassert -> s3_cs_n=0 the following edge.

Source files
------------

// File: rtl/bus_addr_dec_pkg.sv
// Shared bus constants: word address geometry, slave index field location,
// slave index codes and active-low select levels.
package bus_addr_dec_pkg;

    localparam int WORD_ADDR_W         = 30;
    localparam int BUS_SLAVE_INDEX_W   = 3;
    localparam int BUS_SLAVE_INDEX_MSB = 29;
    localparam int BUS_SLAVE_INDEX_LSB = BUS_SLAVE_INDEX_MSB - BUS_SLAVE_INDEX_W + 1;
    localparam int NUM_SLAVES          = 2 ** BUS_SLAVE_INDEX_W;

    typedef logic [WORD_ADDR_W-1:0]       word_addr_t;
    typedef logic [BUS_SLAVE_INDEX_W-1:0] slave_idx_t;
    typedef logic [NUM_SLAVES-1:0]        cs_n_vec_t;

    localparam slave_idx_t BUS_SLAVE_0 = 3'h0;
    localparam slave_idx_t BUS_SLAVE_1 = 3'h1;
    localparam slave_idx_t BUS_SLAVE_2 = 3'h2;
    localparam slave_idx_t BUS_SLAVE_3 = 3'h3;
    localparam slave_idx_t BUS_SLAVE_4 = 3'h4;
    localparam slave_idx_t BUS_SLAVE_5 = 3'h5;
    localparam slave_idx_t BUS_SLAVE_6 = 3'h6;
    localparam slave_idx_t BUS_SLAVE_7 = 3'h7;

    localparam logic ENABLE_N     = 1'b0;
    localparam logic DISABLE_N    = 1'b1;
    localparam logic RESET_ENABLE = 1'b1;

endpackage

// File: rtl/bus_addr_dec_idx.sv
// Combinational slave index to active-low one-hot chip select decode.
module bus_addr_dec_idx
    import bus_addr_dec_pkg::*;
(
    input  logic [BUS_SLAVE_INDEX_W-1:0] idx_i,
    output logic [NUM_SLAVES-1:0]        cs_n_o
);

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
            assign cs_n_o[gi] = (idx_i == slave_idx_t'(gi)) ? ENABLE_N : DISABLE_N;
        end
    endgenerate

endmodule

// File: rtl/bus_addr_dec.sv
// Shared-bus address decoder: top three word-address bits select one of
// eight registered active-low chip selects.
module bus_addr_dec
    import bus_addr_dec_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WORD_ADDR_W-1:0] s_addr,
    output logic                   s0_cs_n,
    output logic                   s1_cs_n,
    output logic                   s2_cs_n,
    output logic                   s3_cs_n,
    output logic                   s4_cs_n,
    output logic                   s5_cs_n,
    output logic                   s6_cs_n,
    output logic                   s7_cs_n
);

    slave_idx_t slave_idx;
    cs_n_vec_t  cs_n_d;
    cs_n_vec_t  cs_n_q;

    // Offset bits within a slave window play no part in selection.
    logic unused_addr_bits;
    assign unused_addr_bits = ^s_addr[BUS_SLAVE_INDEX_LSB-1:0];

    assign slave_idx = s_addr[BUS_SLAVE_INDEX_MSB:BUS_SLAVE_INDEX_LSB];

    bus_addr_dec_idx u_idx_dec (
        .idx_i  (slave_idx),
        .cs_n_o (cs_n_d)
    );

    always_ff @(posedge clk) begin
        if (reset == RESET_ENABLE) begin
            cs_n_q <= {NUM_SLAVES{DISABLE_N}};
        end else begin
            cs_n_q <= cs_n_d;
        end
    end

    assign s0_cs_n = cs_n_q[0];
    assign s1_cs_n = cs_n_q[1];
    assign s2_cs_n = cs_n_q[2];
    assign s3_cs_n = cs_n_q[3];
    assign s4_cs_n = cs_n_q[4];
    assign s5_cs_n = cs_n_q[5];
    assign s6_cs_n = cs_n_q[6];
    assign s7_cs_n = cs_n_q[7];

endmodule

// File: tb/tb_bus_addr_dec.sv
// Scoreboard bench for bus_addr_dec: stimulus pushes the expected select
// vector per cycle, a monitor pops and compares one vector per clock edge.
module tb_bus_addr_dec;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] s_addr;
    logic        s0_cs_n, s1_cs_n, s2_cs_n, s3_cs_n;
    logic        s4_cs_n, s5_cs_n, s6_cs_n, s7_cs_n;

    typedef struct {
        logic [7:0] exp;
        string      name;
    } item_t;

    item_t sb_q[$];
    int    total = 0;
    int    bad   = 0;

    always #5 clk = ~clk;

    bus_addr_dec dut (
        .clk     (clk),
        .reset   (reset),
        .s_addr  (s_addr),
        .s0_cs_n (s0_cs_n),
        .s1_cs_n (s1_cs_n),
        .s2_cs_n (s2_cs_n),
        .s3_cs_n (s3_cs_n),
        .s4_cs_n (s4_cs_n),
        .s5_cs_n (s5_cs_n),
        .s6_cs_n (s6_cs_n),
        .s7_cs_n (s7_cs_n)
    );

    // Drive one cycle of stimulus at the falling edge; exp_idx < 0 means
    // no slave is expected to be selected.
    task automatic step(input logic r, input logic [29:0] a, input int exp_idx,
                        input string name);
        item_t it;
        @(negedge clk);
        reset  = r;
        s_addr = a;
        it.exp  = 8'hFF;
        if (exp_idx >= 0) it.exp[exp_idx] = 1'b0;
        it.name = name;
        sb_q.push_back(it);
    endtask

    // Monitor: the edge after a push captures that stimulus.
    initial begin
        logic [7:0] act;
        item_t      it;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                it  = sb_q.pop_front();
                act = {s7_cs_n, s6_cs_n, s5_cs_n, s4_cs_n,
                       s3_cs_n, s2_cs_n, s1_cs_n, s0_cs_n};
                total++;
                if (act !== it.exp) begin
                    bad++;
                    $display("FAIL %s: cs_n actual=%b required=%b", it.name, act, it.exp);
                end else begin
                    $display("ok   %s: cs_n=%b", it.name, act);
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        reset  = 1'b1;
        s_addr = 30'h0;

        step(1'b1, 30'h0000_0000, -1, "reset_cycle0");
        step(1'b1, 30'h0000_0000, -1, "reset_cycle1");
        step(1'b0, 30'h0000_0000, 0,  "first_after_reset");

        // Sweep in 0x0100_0000 steps: every 8 steps moves to the next window.
        for (int i = 0; i < 64; i++) begin
            step(1'b0, 30'(i) << 24, i / 8, $sformatf("sweep_%08h", i << 24));
        end

        step(1'b0, 30'h07FF_FFFF, 0, "bound_s0_top");
        step(1'b0, 30'h0800_0000, 1, "bound_s1_base");
        step(1'b0, 30'h2000_0000, 4, "low_bits_s4_base");
        step(1'b0, 30'h27FF_FFFF, 4, "low_bits_s4_top");
        step(1'b0, 30'h0FFF_FFFF, 1, "bound_s1_top");
        step(1'b0, 30'h3FFF_FFFF, 7, "bound_s7_top");

        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) step(1'b0, 30'h0000_0000, 0, $sformatf("alt_s0_%0d", i));
            else            step(1'b0, 30'h3800_0000, 7, $sformatf("alt_s7_%0d", i));
        end

        step(1'b0, 30'h1800_0000, 3,  "mid_pre_s3");
        step(1'b1, 30'h1800_0000, -1, "mid_reset");
        step(1'b0, 30'h1800_0000, 3,  "mid_post_s3");
        step(1'b1, 30'h3000_0000, -1, "mid_reset_s6addr");
        step(1'b0, 30'h3000_0000, 6,  "post_reset_s6");

        wait_cycles = 0;
        while (sb_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (sb_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending actual=%0d required=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
